// File: rtl/router_ordermap_sched.sv
// router_ordermap_sched: round-robin front-end for router_ordermap with an order_id
// read-after-write interlock. Optional hazard statistics: define ROUTER_SCHED_STATS_EN.
package pipebomb_pkg;
  localparam int ORDER_ID_W = 16;
  localparam int QTY_W      = 16;

  typedef logic [ORDER_ID_W-1:0] order_id_t;

  typedef enum logic [2:0] {
    ITCH_NOP     = 3'd0,
    ITCH_ADD     = 3'd1,
    ITCH_EXEC    = 3'd2,
    ITCH_CANCEL  = 3'd3,
    ITCH_DELETE  = 3'd4,
    ITCH_REPLACE = 3'd5
  } opcode_e;

  typedef struct packed {
    opcode_e          opcode;
    order_id_t        order_id;
    logic [QTY_W-1:0] qty;
  } inst_t;
endpackage

module router_ordermap_sched
  import pipebomb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int INFLIGHT_MAX = 3
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NUM_REQ-1:0]  req_v,
  output logic [NUM_REQ-1:0]  req_r,
  input  inst_t [NUM_REQ-1:0] req_d,
  output logic                out_v,
  input  logic                out_r,
  output inst_t               out_d,
  input  logic                ret_v,
  output logic                err_underflow,
  output logic [31:0]         hazard_stall_cnt
);

  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = (INFLIGHT_MAX > 1) ? $clog2(INFLIGHT_MAX) : 1;
  localparam int CW = $clog2(INFLIGHT_MAX + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(INFLIGHT_MAX);

  // In-flight table: payload per slot plus a live bit per slot.
  order_id_t               r_tab_id [INFLIGHT_MAX];
  logic [INFLIGHT_MAX-1:0] r_tab_cmp;
  logic [INFLIGHT_MAX-1:0] r_tab_v;
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic [RW-1:0]           r_rr_ptr;
  logic                    r_out_v;
  inst_t                   r_out_d;
  logic                    r_err_underflow;

  logic [NUM_REQ-1:0] w_blocked;
  logic [NUM_REQ-1:0] w_eligible;
  logic [RW:0]        w_idx;
  logic [RW-1:0]      w_grant;
  logic               w_found;
  logic               w_full;
  logic               w_can_accept;
  logic               w_accept;
  logic               w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(INFLIGHT_MAX - 1)) ? '0 : p + PW'(1);
  endfunction

  // An entry that is popping this cycle still blocks: the check uses registered state only.
  always_comb begin
    w_blocked = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < INFLIGHT_MAX; j++) begin
        if (req_v[i] && (req_d[i].opcode != ITCH_NOP) && r_tab_v[j] && r_tab_cmp[j] &&
            (r_tab_id[j] == req_d[i].order_id)) begin
          w_blocked[i] = 1'b1;
        end
      end
    end
  end

  assign w_eligible = req_v & ~w_blocked;

  // NOTE: combinational blocks use blocking assignments with every output defaulted
  // first, so the scan reads its own partial results and no latch is inferred.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (RW+1)'(k);
      if (w_idx >= (RW+1)'(NUM_REQ)) begin
        w_idx = w_idx - (RW+1)'(NUM_REQ);
      end
      if (!w_found && w_eligible[w_idx[RW-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_idx[RW-1:0];
      end
    end
  end

  assign w_full       = (r_count == FULL_CNT);
  assign w_can_accept = (!r_out_v || out_r) && !w_full;
  // Gating with rstn keeps req_r at zero while reset is held.
  assign w_accept     = rstn && w_can_accept && w_found;
  assign w_pop        = ret_v && (r_count != '0);
  assign req_r        = w_accept ? (NUM_REQ'(1) << w_grant) : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tab_v         <= '0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_rr_ptr        <= '0;
      r_out_v         <= 1'b0;
      r_out_d         <= '0;
      r_err_underflow <= 1'b0;
    end else begin
      if (w_pop) begin
        r_tab_v[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= ptr_inc(r_rd_ptr);
      end
      if (w_accept) begin
        r_tab_v[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= ptr_inc(r_wr_ptr);
        r_rr_ptr          <= (w_grant == RW'(NUM_REQ - 1)) ? '0 : w_grant + RW'(1);
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (ret_v && (r_count == '0)) begin
        r_err_underflow <= 1'b1;
      end
      if (w_accept) begin
        r_out_v <= 1'b1;
        r_out_d <= req_d[w_grant];
      end else if (out_r) begin
        r_out_v <= 1'b0;
      end
    end
  end

  // NOTE: table payload is not reset; r_tab_v alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_tab_id[r_wr_ptr]  <= req_d[w_grant].order_id;
      r_tab_cmp[r_wr_ptr] <= (req_d[w_grant].opcode != ITCH_NOP);
    end
  end

  assign out_v         = r_out_v;
  assign out_d         = r_out_d;
  assign err_underflow = r_err_underflow;

`ifdef ROUTER_SCHED_STATS_EN
  logic [31:0] r_hz_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hz_cnt <= '0;
    end else if ((|w_blocked) && (r_hz_cnt != '1)) begin
      r_hz_cnt <= r_hz_cnt + 32'd1;
    end
  end

  assign hazard_stall_cnt = r_hz_cnt;
`else
  assign hazard_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_router_ordermap_sched.sv
// Directed bench for router_ordermap_sched: per-stream head queues, a one-stage commit
// model for ret_v, and a scoreboard of expected out_d values in issue order.
module tb_router_ordermap_sched;
  import pipebomb_pkg::*;

`ifdef ROUTER_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rstn;
  logic [1:0]  req_v;
  logic [1:0]  req_r;
  inst_t [1:0] req_d;
  logic        out_v;
  logic        out_r;
  inst_t       out_d;
  logic        ret_v;
  logic        err_underflow;
  logic [31:0] hazard_stall_cnt;

  router_ordermap_sched #(.NUM_REQ(2), .INFLIGHT_MAX(3)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .req_v            (req_v),
    .req_r            (req_r),
    .req_d            (req_d),
    .out_v            (out_v),
    .out_r            (out_r),
    .out_d            (out_d),
    .ret_v            (ret_v),
    .err_underflow    (err_underflow),
    .hazard_stall_cnt (hazard_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  inst_t sq0[$];
  inst_t sq1[$];
  inst_t exp_q[$];
  logic [1:0] last_req_r;
  logic       last_hs;
  bit         auto_ret;
  bit         man_ret;

  function automatic inst_t mk(input opcode_e op, input logic [15:0] id);
    inst_t t;
    t.opcode   = op;
    t.order_id = id;
    t.qty      = id ^ 16'h00a5;
    return t;
  endfunction

  function automatic logic [63:0] stall_exp(input int n);
    return STATS ? 64'(n) : 64'd0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    req_v[0] = (sq0.size() != 0);
    req_v[1] = (sq1.size() != 0);
    req_d[0] = (sq0.size() != 0) ? sq0[0] : '0;
    req_d[1] = (sq1.size() != 0) ? sq1[0] : '0;
  endtask

  // One clock: sample at negedge, score a handshake, then advance heads and the commit model.
  task automatic tick();
    @(negedge clk);
    last_req_r = req_r;
    last_hs    = out_v && out_r;
    if (last_hs) begin
      check("sb_expect", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("sb_out_d", 64'(out_d), 64'(exp_q.pop_front()));
    end
    @(posedge clk);
    #1;
    if (last_req_r[0] && (sq0.size() != 0)) sq0.delete(0);
    if (last_req_r[1] && (sq1.size() != 0)) sq1.delete(0);
    refresh();
    ret_v = (auto_ret && last_hs) || man_ret;
  endtask

  task automatic grant(input string tag, input logic [1:0] exp);
    tick();
    check(tag, 64'(last_req_r), 64'(exp));
  endtask

  task automatic drain();
    repeat (4) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn     = 1'b0;
    req_v    = '0;
    req_d    = '0;
    out_r    = 1'b1;
    ret_v    = 1'b0;
    auto_ret = 1'b0;
    man_ret  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    req_v    = 2'b11;
    req_d[0] = mk(ITCH_ADD, 16'h0001);
    req_d[1] = mk(ITCH_ADD, 16'h0002);
    #1;
    check("rst_req_r", 64'(req_r), 64'd0);
    check("rst_out_v", 64'(out_v), 64'd0);
    check("rst_out_d", 64'(out_d), 64'd0);
    check("rst_err", 64'(err_underflow), 64'd0);
    check("rst_cnt", 64'(hazard_stall_cnt), 64'd0);
    req_v = '0;
    req_d = '0;
    rstn  = 1'b1;
    @(posedge clk);
    #1;

    // Round-robin: req0 {1,2}, req1 {3,4} interleave as 1,3,2,4 at one per cycle.
    auto_ret = 1'b1;
    sq0 = '{mk(ITCH_ADD, 16'd1), mk(ITCH_ADD, 16'd2)};
    sq1 = '{mk(ITCH_ADD, 16'd3), mk(ITCH_ADD, 16'd4)};
    exp_q = '{mk(ITCH_ADD, 16'd1), mk(ITCH_ADD, 16'd3), mk(ITCH_ADD, 16'd2), mk(ITCH_ADD, 16'd4)};
    refresh();
    grant("rr_g0", 2'b01);
    grant("rr_g1", 2'b10);
    grant("rr_g2", 2'b01);
    grant("rr_g3", 2'b10);
    drain();
    check("rr_sb_empty", 64'(exp_q.size()), 64'd0);

    // Hazard with bypass: CANCEL 0x55 waits for 0x55 to retire while 0x66 goes by.
    sq0 = '{mk(ITCH_ADD, 16'h0055), mk(ITCH_ADD, 16'h0066)};
    sq1 = '{mk(ITCH_CANCEL, 16'h0055)};
    exp_q = '{mk(ITCH_ADD, 16'h0055), mk(ITCH_ADD, 16'h0066), mk(ITCH_CANCEL, 16'h0055)};
    refresh();
    grant("hz_issue55", 2'b01);
    grant("hz_bypass66", 2'b01);
    grant("hz_blocked", 2'b00);
    grant("hz_cancel", 2'b10);
    check("hz_stall_cnt", 64'(hazard_stall_cnt), stall_exp(2));
    drain();

    // Full table: no retirements, fourth id waits until the cycle after the first ret_v.
    auto_ret = 1'b0;
    sq0 = '{mk(ITCH_ADD, 16'h0010), mk(ITCH_ADD, 16'h0011)};
    sq1 = '{mk(ITCH_ADD, 16'h0020), mk(ITCH_ADD, 16'h0021)};
    exp_q = '{mk(ITCH_ADD, 16'h0010), mk(ITCH_ADD, 16'h0020), mk(ITCH_ADD, 16'h0011),
              mk(ITCH_ADD, 16'h0021)};
    refresh();
    grant("full_a0", 2'b01);
    grant("full_a1", 2'b10);
    grant("full_a2", 2'b01);
    grant("full_held0", 2'b00);
    grant("full_held1", 2'b00);
    grant("full_held2", 2'b00);
    ret_v = 1'b1;
    grant("full_ret_cycle", 2'b00);
    grant("full_after_ret", 2'b10);
    check("full_no_underflow", 64'(err_underflow), 64'd0);
    ret_v   = 1'b1;
    man_ret = 1'b1;
    repeat (3) tick();
    check("uf_before", 64'(err_underflow), 64'd0);
    man_ret = 1'b0;
    tick();
    check("uf_set", 64'(err_underflow), 64'd1);
    tick();
    check("uf_sticky", 64'(err_underflow), 64'd1);
    check("full_sb_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: out_d frozen and req_r low while out_r is held low.
    auto_ret = 1'b1;
    out_r    = 1'b0;
    sq0 = '{mk(ITCH_ADD, 16'h0030)};
    sq1 = '{mk(ITCH_EXEC, 16'h0031)};
    exp_q = '{mk(ITCH_ADD, 16'h0030), mk(ITCH_EXEC, 16'h0031)};
    refresh();
    grant("bp_first", 2'b01);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_req_r", 64'(last_req_r), 64'd0);
      check("bp_out_v", 64'(out_v), 64'd1);
      check("bp_out_d", 64'(out_d), 64'(mk(ITCH_ADD, 16'h0030)));
    end
    out_r = 1'b1;
    grant("bp_release", 2'b10);
    drain();
    check("bp_sb_empty", 64'(exp_q.size()), 64'd0);

    // NOPs never match, so NOP,NOP,ADD on id 0 issue on consecutive cycles.
    sq0 = '{mk(ITCH_NOP, 16'h0000), mk(ITCH_NOP, 16'h0000), mk(ITCH_ADD, 16'h0000)};
    exp_q = '{mk(ITCH_NOP, 16'h0000), mk(ITCH_NOP, 16'h0000), mk(ITCH_ADD, 16'h0000)};
    refresh();
    grant("nop_0", 2'b01);
    grant("nop_1", 2'b01);
    grant("nop_add", 2'b01);
    drain();

    // Same order_id back-to-back on one stream: three-cycle spacing.
    sq0 = '{mk(ITCH_ADD, 16'h0077), mk(ITCH_EXEC, 16'h0077)};
    exp_q = '{mk(ITCH_ADD, 16'h0077), mk(ITCH_EXEC, 16'h0077)};
    refresh();
    grant("sp_first", 2'b01);
    grant("sp_wait0", 2'b00);
    grant("sp_wait1", 2'b00);
    grant("sp_second", 2'b01);
    check("sp_stall_cnt", 64'(hazard_stall_cnt), stall_exp(4));
    drain();
    check("sp_sb_empty", 64'(exp_q.size()), 64'd0);

    // Reset mid-traffic: everything returns to reset values and the table is flushed.
    sq0 = '{mk(ITCH_ADD, 16'h0040), mk(ITCH_ADD, 16'h0041)};
    sq1 = '{mk(ITCH_ADD, 16'h0050)};
    exp_q = '{mk(ITCH_ADD, 16'h0050), mk(ITCH_ADD, 16'h0040)};
    refresh();
    grant("mr_g0", 2'b10);
    grant("mr_g1", 2'b01);
    #2;
    rstn = 1'b0;
    #1;
    check("mr_req_r", 64'(req_r), 64'd0);
    check("mr_out_v", 64'(out_v), 64'd0);
    check("mr_out_d", 64'(out_d), 64'd0);
    check("mr_err", 64'(err_underflow), 64'd0);
    check("mr_cnt", 64'(hazard_stall_cnt), 64'd0);
    exp_q.delete();
    sq0.delete();
    sq1.delete();
    refresh();
    ret_v   = 1'b0;
    man_ret = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    sq0 = '{mk(ITCH_DELETE, 16'h0040)};
    sq1 = '{mk(ITCH_DELETE, 16'h0050)};
    exp_q = '{mk(ITCH_DELETE, 16'h0040), mk(ITCH_DELETE, 16'h0050)};
    refresh();
    grant("post_rst_g0", 2'b01);
    grant("post_rst_g1", 2'b10);
    drain();
    check("final_sb_empty", 64'(exp_q.size()), 64'd0);
    check("final_err", 64'(err_underflow), 64'd0);
    check("final_cnt", 64'(hazard_stall_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
